// File: rtl/mnacidpro_pkg.sv
// Shared types and constants for the nucleic-acid purification sequencer:
// state encoding, valve bit positions and peristaltic pump patterns.
package mnacidpro_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_LYSIS   = 4'd2,
        ST_WASH    = 4'd3,
        ST_ELUTE   = 4'd4,
        ST_COLLECT = 4'd5,
        ST_FLUSH   = 4'd6,
        ST_DONE    = 4'd7,
        ST_SETTLE  = 4'd8
    } state_e;

    localparam int LYSIS_V     = 0;
    localparam int WASH_V      = 1;
    localparam int ELUTE_V     = 2;
    localparam int BEAD_V      = 3;
    localparam int VERTICAL_V  = 4;
    localparam int HORIZ_V     = 5;
    localparam int LOOP_EXIT_V = 6;
    localparam int WASTE_V     = 7;
    localparam int DEAD_END_V  = 8;
    localparam int BEAD_TRAP_V = 9;
    localparam int NUM_FIXED_V = 10;

    localparam logic [2:0] PUMP_P0   = 3'b110;
    localparam logic [2:0] PUMP_P1   = 3'b101;
    localparam logic [2:0] PUMP_P2   = 3'b011;
    localparam logic [2:0] PUMP_IDLE = 3'b111;

    function automatic logic is_pumped(input state_e st);
        return (st == ST_LOAD) || (st == ST_LYSIS) || (st == ST_WASH) ||
               (st == ST_ELUTE) || (st == ST_COLLECT);
    endfunction

    // Fixed valves opened by each pumped step; the collect outlet is added by the caller.
    function automatic logic [NUM_FIXED_V-1:0] fixed_open_set(input state_e st);
        logic [NUM_FIXED_V-1:0] m;
        m = '0;
        case (st)
            ST_LOAD: begin
                m[BEAD_V] = 1'b1; m[HORIZ_V] = 1'b1; m[WASTE_V] = 1'b1;
            end
            ST_LYSIS: begin
                m[LYSIS_V] = 1'b1; m[VERTICAL_V] = 1'b1;
                m[LOOP_EXIT_V] = 1'b1; m[WASTE_V] = 1'b1;
            end
            ST_WASH: begin
                m[WASH_V] = 1'b1; m[VERTICAL_V] = 1'b1;
                m[LOOP_EXIT_V] = 1'b1; m[WASTE_V] = 1'b1;
            end
            ST_ELUTE: begin
                m[ELUTE_V] = 1'b1; m[VERTICAL_V] = 1'b1;
                m[LOOP_EXIT_V] = 1'b1; m[DEAD_END_V] = 1'b1;
            end
            ST_COLLECT: begin
                m[LOOP_EXIT_V] = 1'b1; m[HORIZ_V] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // SETTLE has no 3-bit code of its own; it reads as 0 with busy high.
    function automatic logic [2:0] step_code(input state_e st);
        logic [3:0] s;
        s = st;
        return s[2:0];
    endfunction

endpackage

// File: rtl/mnacidpro_pump_phaser.sv
// Three-phase peristaltic pump driver: holds each pattern for PUMP_DIV cycles,
// restarts at the first pattern on request and idles closed when disabled.
module mnacidpro_pump_phaser
    import mnacidpro_pkg::*;
#(
    parameter int PUMP_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    output logic [2:0] pump
);

    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       pump_q, pump_d;

    function automatic logic [2:0] pattern(input logic [1:0] ph);
        case (ph)
            2'd0:    return PUMP_P0;
            2'd1:    return PUMP_P1;
            default: return PUMP_P2;
        endcase
    endfunction

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (!en || restart) begin
            div_d   = '0;
            phase_d = 2'd0;
        end else if (div_q == DIV_W'(PUMP_DIV - 1)) begin
            div_d   = '0;
            phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        pump_d = en ? pattern(phase_d) : PUMP_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= 2'd0;
            pump_q  <= PUMP_IDLE;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            pump_q  <= pump_d;
        end
    end

    assign pump = pump_q;

endmodule

// File: rtl/mnacidpro_sequencer.sv
// Timed valve/pump sequencer: LOAD, LYSIS, WASH xN, ELUTE, COLLECT, FLUSH on one start.
// Every output is decoded from the next state and registered.
module mnacidpro_sequencer
    import mnacidpro_pkg::*;
#(
    parameter int SIZE      = 3,
    parameter int STEP_W    = 16,
    parameter int PUMP_DIV  = 4,
    parameter int FLUSH_LEN = 8,
    localparam int CH_W     = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int NV       = NUM_FIXED_V + SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CH_W-1:0]   chan_sel,
    input  logic [3:0]        wash_reps,
    input  logic [STEP_W-1:0] step_len,
    output logic              lysis_ctrl,
    output logic              wash_ctrl,
    output logic              elute_ctrl,
    output logic              bead_ctrl,
    output logic              vertical_ctrl,
    output logic              horiz_ctrl,
    output logic              loop_exit_ctrl,
    output logic              waste_ctrl,
    output logic              dead_end_ctrl,
    output logic              bead_trap_ctrl,
    output logic [SIZE-1:0]   collect_ctrl,
    output logic [2:0]        pump,
    output logic [NV-1:0]     flush,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        step_id
);

    state_e            state_q, state_d;
    state_e            ret_q, ret_d;
    logic [STEP_W-1:0] dwell_q, dwell_d;
    logic [3:0]        wash_q, wash_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [3:0]        reps_q, reps_d;
    logic [STEP_W-1:0] len_q, len_d;
    logic              abort_q, abort_d;
    logic [NV-1:0]     ctrl_q, ctrl_d;
    logic [NV-1:0]     flush_q, flush_d;
    logic              flush_act_q, flush_act_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        step_q, step_d;

    logic              bad_start;
    logic              step_last;
    logic              can_abort;
    logic [STEP_W-1:0] len_eff;
    logic [NV-1:0]     open_set;
    logic              pump_en, pump_restart;
    logic [2:0]        phase_pump;

    assign len_eff   = (len_q == '0) ? STEP_W'(1) : len_q;
    assign step_last = (dwell_q == len_eff - STEP_W'(1));
    assign can_abort = (state_q == ST_LOAD) || (state_q == ST_LYSIS) || (state_q == ST_WASH) ||
                       (state_q == ST_ELUTE) || (state_q == ST_COLLECT) || (state_q == ST_SETTLE);

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        dwell_d   = (dwell_q == '1) ? dwell_q : dwell_q + STEP_W'(1);
        wash_d    = wash_q;
        chan_d    = chan_q;
        reps_d    = reps_q;
        len_d     = len_q;
        abort_d   = abort_q;
        err_d     = err_q;
        bad_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (int'(chan_sel) < SIZE) begin
                        state_d = ST_LOAD;
                        chan_d  = chan_sel;
                        reps_d  = wash_reps;
                        len_d   = step_len;
                        wash_d  = '0;
                        abort_d = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        bad_start = 1'b1;
                        err_d     = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (step_last) begin
                    state_d = ST_SETTLE;
                    ret_d   = ST_LYSIS;
                end
            end
            ST_LYSIS: begin
                if (step_last) begin
                    state_d = ST_SETTLE;
                    ret_d   = (reps_q != 4'd0) ? ST_WASH : ST_ELUTE;
                end
            end
            ST_WASH: begin
                if (step_last) begin
                    state_d = ST_SETTLE;
                    wash_d  = wash_q + 4'd1;
                    // widened compare so a count of 15 cannot wrap past the target
                    ret_d   = (({1'b0, wash_q} + 5'd1) >= {1'b0, reps_q}) ? ST_ELUTE : ST_WASH;
                end
            end
            ST_ELUTE: begin
                if (step_last) begin
                    state_d = ST_SETTLE;
                    ret_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (step_last) begin
                    state_d = ST_SETTLE;
                    ret_d   = ST_FLUSH;
                end
            end
            ST_SETTLE: state_d = ret_q;
            ST_FLUSH: begin
                if (dwell_q == STEP_W'(FLUSH_LEN - 1)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (can_abort && abort) begin
            state_d = ST_FLUSH;
            abort_d = 1'b1;
        end

        if (state_d != state_q) dwell_d = '0;
        if (state_d == ST_DONE) err_d = abort_d;

        open_set = {{SIZE{1'b0}}, fixed_open_set(state_d)};
        if (state_d == ST_COLLECT) begin
            for (int i = 0; i < SIZE; i++) begin
                if (int'(chan_d) == i) open_set[NUM_FIXED_V + i] = 1'b1;
            end
        end

        flush_act_d = (state_d == ST_FLUSH);
        ctrl_d      = flush_act_d ? '0 : ~open_set;
        flush_d     = flush_act_d ? '1 : '0;
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE) || bad_start;
        step_d      = step_code(state_d);

        pump_en      = is_pumped(state_d);
        pump_restart = pump_en && (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            dwell_q     <= '0;
            wash_q      <= '0;
            chan_q      <= '0;
            reps_q      <= '0;
            len_q       <= '0;
            abort_q     <= 1'b0;
            ctrl_q      <= '1;
            flush_q     <= '0;
            flush_act_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            step_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            dwell_q     <= dwell_d;
            wash_q      <= wash_d;
            chan_q      <= chan_d;
            reps_q      <= reps_d;
            len_q       <= len_d;
            abort_q     <= abort_d;
            ctrl_q      <= ctrl_d;
            flush_q     <= flush_d;
            flush_act_q <= flush_act_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            step_q      <= step_d;
        end
    end

    mnacidpro_pump_phaser #(
        .PUMP_DIV (PUMP_DIV)
    ) u_pump (
        .clk     (clk),
        .rst     (rst),
        .en      (pump_en),
        .restart (pump_restart),
        .pump    (phase_pump)
    );

    // the phaser idles closed outside pumped steps; FLUSH forces every pump valve open
    assign pump = flush_act_q ? 3'b000 : phase_pump;

    assign lysis_ctrl     = ctrl_q[LYSIS_V];
    assign wash_ctrl      = ctrl_q[WASH_V];
    assign elute_ctrl     = ctrl_q[ELUTE_V];
    assign bead_ctrl      = ctrl_q[BEAD_V];
    assign vertical_ctrl  = ctrl_q[VERTICAL_V];
    assign horiz_ctrl     = ctrl_q[HORIZ_V];
    assign loop_exit_ctrl = ctrl_q[LOOP_EXIT_V];
    assign waste_ctrl     = ctrl_q[WASTE_V];
    assign dead_end_ctrl  = ctrl_q[DEAD_END_V];
    assign bead_trap_ctrl = ctrl_q[BEAD_TRAP_V];
    assign collect_ctrl   = ctrl_q[NUM_FIXED_V +: SIZE];
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign step_id        = step_q;

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// Directed bench for mnacidpro_sequencer: an expected per-cycle output record is queued for
// every cycle of each scenario and compared against the DUT on the falling clock edge.
module tb_mnacidpro_sequencer;

    localparam int SIZE = 3;
    localparam int NVB  = 10 + SIZE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  chan_sel = '0;
    logic [3:0]  wash_reps = '0;
    logic [15:0] step_len = '0;

    logic lysis_ctrl, wash_ctrl, elute_ctrl, bead_ctrl, vertical_ctrl, horiz_ctrl;
    logic loop_exit_ctrl, waste_ctrl, dead_end_ctrl, bead_trap_ctrl;
    logic [SIZE-1:0] collect_ctrl;
    logic [2:0]      pump;
    logic [NVB-1:0]  flush;
    logic            busy, done, err;
    logic [2:0]      step_id;

    mnacidpro_sequencer #(
        .SIZE(SIZE), .STEP_W(16), .PUMP_DIV(4), .FLUSH_LEN(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .chan_sel(chan_sel),
        .wash_reps(wash_reps), .step_len(step_len),
        .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
        .bead_ctrl(bead_ctrl), .vertical_ctrl(vertical_ctrl), .horiz_ctrl(horiz_ctrl),
        .loop_exit_ctrl(loop_exit_ctrl), .waste_ctrl(waste_ctrl), .dead_end_ctrl(dead_end_ctrl),
        .bead_trap_ctrl(bead_trap_ctrl), .collect_ctrl(collect_ctrl), .pump(pump),
        .flush(flush), .busy(busy), .done(done), .err(err), .step_id(step_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]     step;
        logic [NVB-1:0] ctrl;
        logic [NVB-1:0] flsh;
        logic [2:0]     pmp;
        logic           bsy;
        logic           dn;
        logic           er;
    } rec_t;

    rec_t expq[$];
    bit   abq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_at;
    int   wash_seen;
    logic cur_err = 1'b0;

    // open masks, bit order lysis,wash,elute,bead,vertical,horiz,loop_exit,waste,dead_end,bead_trap,collect[]
    localparam logic [NVB-1:0] M_LOAD  = 13'b000_0_0_1_0_1_0_1_0_0_0;
    localparam logic [NVB-1:0] M_LYSIS = 13'b000_0_0_1_1_0_1_0_0_0_1;
    localparam logic [NVB-1:0] M_WASH  = 13'b000_0_0_1_1_0_1_0_0_1_0;
    localparam logic [NVB-1:0] M_ELUTE = 13'b000_0_1_0_1_0_1_0_1_0_0;
    localparam logic [NVB-1:0] M_COLL  = 13'b000_0_0_0_1_1_0_0_0_0_0;

    function automatic logic [2:0] pat(input int c);
        case ((c / 4) % 3)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic push_rec(input logic [2:0] st, input logic [NVB-1:0] ctl, input logic [NVB-1:0] fl,
                            input logic [2:0] pm, input logic b, input logic d, input logic e, input bit ab);
        rec_t r;
        r.step = st; r.ctrl = ctl; r.flsh = fl; r.pmp = pm; r.bsy = b; r.dn = d; r.er = e;
        expq.push_back(r);
        abq.push_back(ab);
    endtask

    task automatic push_step(input logic [2:0] st, input int len, input logic [NVB-1:0] openm,
                             input int abort_at);
        for (int c = 0; c < len; c++)
            push_rec(st, ~openm, '0, pat(c), 1'b1, 1'b0, cur_err, (c == abort_at));
    endtask

    task automatic push_settle();
        push_rec(3'd0, '1, '0, 3'b111, 1'b1, 1'b0, cur_err, 1'b0);
    endtask

    task automatic push_tail(input logic e, input int idles);
        for (int c = 0; c < 8; c++) push_rec(3'd6, '0, '1, 3'b000, 1'b1, 1'b0, cur_err, 1'b0);
        cur_err = e;
        push_rec(3'd7, '1, '0, 3'b111, 1'b0, 1'b1, cur_err, 1'b0);
        for (int c = 0; c < idles; c++) push_rec(3'd0, '1, '0, 3'b111, 1'b0, 1'b0, cur_err, 1'b0);
    endtask

    task automatic push_run(input int len, input int reps, input int chan);
        int l;
        logic [NVB-1:0] mc;
        l = (len == 0) ? 1 : len;
        mc = M_COLL;
        mc[10 + chan] = 1'b1;
        cur_err = 1'b0;
        push_step(3'd1, l, M_LOAD, -1);  push_settle();
        push_step(3'd2, l, M_LYSIS, -1); push_settle();
        for (int r = 0; r < reps; r++) begin
            push_step(3'd3, l, M_WASH, -1); push_settle();
        end
        push_step(3'd4, l, M_ELUTE, -1); push_settle();
        push_step(3'd5, l, mc, -1);      push_settle();
        push_tail(1'b0, 2);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_start(input int chan, input int reps, input int len);
        chan_sel  = 2'(chan);
        wash_reps = 4'(reps);
        step_len  = 16'(len);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // compares up to n queued records (n < 0: all), one per cycle
    task automatic check_q(input string tag, input int n);
        int idx;
        rec_t obs;
        idx = 0;
        done_at = -1;
        wash_seen = 0;
        while (expq.size() > 0 && (n < 0 || idx < n)) begin
            rec_t e;
            bit ab;
            e  = expq.pop_front();
            ab = abq.pop_front();
            obs.step = step_id;
            obs.ctrl = {collect_ctrl, bead_trap_ctrl, dead_end_ctrl, waste_ctrl, loop_exit_ctrl,
                        horiz_ctrl, vertical_ctrl, bead_ctrl, elute_ctrl, wash_ctrl, lysis_ctrl};
            obs.flsh = flush;
            obs.pmp  = pump;
            obs.bsy  = busy;
            obs.dn   = done;
            obs.er   = err;
            chk($sformatf("%s_cyc%0d", tag, idx + 1), 64'(obs), 64'(e));
            if (done === 1'b1 && done_at < 0) done_at = idx + 1;
            if (step_id === 3'd3) wash_seen++;
            abort = ab;
            idx++;
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 20; c++) push_rec(3'd0, '1, '0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        check_q("idle", -1);

        push_run(10, 2, 2);
        drive_start(2, 2, 10);
        check_q("run10", -1);
        chk("done_latency", 64'(done_at), 64'd75);

        push_run(12, 1, 0);
        drive_start(0, 1, 12);
        check_q("pump12", -1);

        push_run(0, 0, 1);
        drive_start(1, 0, 0);
        check_q("len0", -1);
        chk("no_wash", 64'(wash_seen), 64'd0);

        cur_err = 1'b1;
        push_rec(3'd0, '1, '0, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) push_rec(3'd0, '1, '0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_start(3, 1, 5);
        check_q("badchan", -1);
        chk("badchan_done_at", 64'(done_at), 64'd1);

        cur_err = 1'b0;
        push_step(3'd1, 10, M_LOAD, -1);  push_settle();
        push_step(3'd2, 10, M_LYSIS, -1); push_settle();
        push_step(3'd3, 10, M_WASH, -1);  push_settle();
        push_step(3'd4, 4, M_ELUTE, 3);
        push_tail(1'b1, 2);
        drive_start(0, 1, 10);
        check_q("abort", -1);
        chk("abort_done_at", 64'(done_at), 64'(10 + 1 + 10 + 1 + 10 + 1 + 4 + 8 + 1));

        push_run(2, 0, 1);
        drive_start(1, 0, 2);
        check_q("restart", -1);

        cur_err = 1'b0;
        push_step(3'd1, 5, M_LOAD, -1);
        drive_start(0, 1, 5);
        check_q("prerst", 3);
        expq.delete();
        abq.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_rec(3'd0, '1, '0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        push_rec(3'd0, '1, '0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        check_q("midrst", -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
